// File: rtl/exec_wb_pkg.sv
// Shared types and constants for the exec_wb R-type execute/writeback stage.
// Holds the funct encodings, the FSM state enum and the single-cycle ALU helper.
package exec_wb_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_e;

    typedef struct packed {
        logic              legal;
        logic [DATA_W-1:0] res;
    } alu_res_t;

    // MULT is deliberately not legal here; the top handles it separately.
    function automatic alu_res_t alu(input logic [5:0]        f,
                                     input logic [4:0]        sh,
                                     input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
        alu_res_t r;
        r.legal = 1'b1;
        r.res   = '0;
        case (f)
            F_ADD:   r.res = a + b;
            F_SUB:   r.res = a - b;
            F_AND:   r.res = a & b;
            F_OR:    r.res = a | b;
            F_XOR:   r.res = a ^ b;
            F_NOR:   r.res = ~(a | b);
            F_SLT:   r.res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLL:   r.res = b << sh;
            F_SRL:   r.res = b >> sh;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_wb_seq_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// 32 iterations after start; only the low DATA_W product bits are kept.
module seq_mul
    import exec_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    logic              run_q, run_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] step;

    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        step     = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = run_q && (cnt_q == 6'd31);
        // product includes the final iteration so the caller can register it on done
        product  = step;
        if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
        end else if (run_q) begin
            acc_d    = step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (done) begin
                run_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/exec_wb.sv
// R-type execute + register-file writeback stage: single-cycle ALU ops, optional
// iterative MULT when EXEC_WB_MUL_EN is defined (otherwise MULT is illegal).
module exec_wb
    import exec_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              illegal_q, illegal_d;
    logic              accept;
    alu_res_t          alu_r;

`ifdef EXEC_WB_MUL_EN
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic [4:0]        rd_q, rd_d;

    seq_mul u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (opA),
        .b       (opB),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    always_comb begin
        state_d   = state_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        illegal_d = 1'b0;
        in_ready  = (state_q != MUL);
        accept    = in_valid && in_ready;
        alu_r     = alu(funct, shamt, opA, opB);
`ifdef EXEC_WB_MUL_EN
        mul_start = 1'b0;
        rd_d      = rd_q;
`endif
        case (state_q)
            IDLE, WB: begin
                state_d = IDLE;
                if (accept) begin
`ifdef EXEC_WB_MUL_EN
                    if (funct == F_MULT) begin
                        state_d   = MUL;
                        mul_start = 1'b1;
                        rd_d      = rd;
                    end else
`endif
                    if (alu_r.legal) begin
                        state_d   = WB;
                        wb_en_d   = (rd != 5'd0);
                        wb_addr_d = rd;
                        wb_data_d = alu_r.res;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
`ifdef EXEC_WB_MUL_EN
            MUL: begin
                if (mul_done) begin
                    state_d   = WB;
                    wb_en_d   = (rd_q != 5'd0);
                    wb_addr_d = rd_q;
                    wb_data_d = mul_product;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef EXEC_WB_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_d;
    end
    assign busy = (state_q == MUL);
`else
    assign busy = 1'b0;
`endif

    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_exec_wb.sv
// Directed self-checking bench for exec_wb; MULT cases run when EXEC_WB_MUL_EN is defined.
module tb_exec_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic [31:0] opA, opB;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        illegal;

    int n_chk = 0;
    int n_err = 0;

    exec_wb dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .shamt(shamt), .rd(rd), .opA(opA), .opB(opB),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [4:0] r);
        in_valid = 1'b1;
        funct    = f;
        opA      = a;
        opB      = b;
        shamt    = sh;
        rd       = r;
    endtask

    // single op from idle: accept, check the writeback cycle, then the return to idle
    task automatic alu_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [4:0] r,
                          input logic [31:0] exp);
        drive(f, a, b, sh, r);
        tick();
        in_valid = 1'b0;
        opA      = 32'hDEAD_BEEF;
        opB      = 32'h1234_5678;
        chk({tag, "_en"},   {31'b0, wb_en},   32'd1);
        chk({tag, "_addr"}, {27'b0, wb_addr}, {27'b0, r});
        chk({tag, "_data"}, wb_data,          exp);
        tick();
        chk({tag, "_en_off"}, {31'b0, wb_en}, 32'd0);
    endtask

`ifdef EXEC_WB_MUL_EN
    task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp);
        int bad_busy;
        bad_busy = 0;
        drive(6'h18, a, b, 5'd0, r);
        tick();
        in_valid = 1'b0;
        opA      = 32'hFFFF_FFFF;
        opB      = 32'hFFFF_FFFF;
        rd       = 5'd3;
        for (int i = 0; i < 32; i++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || wb_en !== 1'b0) bad_busy++;
            tick();
        end
        chk({tag, "_busy_cycles_bad"}, bad_busy, 0);
        chk({tag, "_en"},   {31'b0, wb_en},   32'd1);
        chk({tag, "_addr"}, {27'b0, wb_addr}, {27'b0, r});
        chk({tag, "_data"}, wb_data,          exp);
        chk({tag, "_busy_off"}, {31'b0, busy}, 32'd0);
        tick();
        chk({tag, "_en_off"}, {31'b0, wb_en}, 32'd0);
    endtask
`endif

    initial begin
        int seen;
        rst_n = 1'b0;
        drive(6'h00, 32'd0, 32'd0, 5'd0, 5'd0);
        in_valid = 1'b0;
        #12;
        chk("rst_wb_en",   {31'b0, wb_en},    32'd0);
        chk("rst_wb_addr", {27'b0, wb_addr},  32'd0);
        chk("rst_wb_data", wb_data,           32'd0);
        chk("rst_busy",    {31'b0, busy},     32'd0);
        chk("rst_illegal", {31'b0, illegal},  32'd0);
        chk("rst_ready",   {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        alu_op("add",      6'h20, 32'd20,        32'd12,        5'd0,  5'd10, 32'd32);
        alu_op("sub",      6'h22, 32'd12,        32'd20,        5'd0,  5'd5,  32'hFFFF_FFF8);
        alu_op("slt",      6'h2A, 32'd12,        32'd20,        5'd0,  5'd6,  32'd1);
        alu_op("slt_neg",  6'h2A, 32'hFFFF_FFFF, 32'd1,         5'd0,  5'd7,  32'd1);
        alu_op("slt_ge",   6'h2A, 32'd5,         32'hFFFF_FFFE, 5'd0,  5'd7,  32'd0);
        alu_op("add_wrap", 6'h20, 32'hFFFF_FFFF, 32'd2,         5'd0,  5'd8,  32'd1);
        alu_op("and",      6'h24, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0,  5'd9,  32'h00F0_000F);
        alu_op("xor",      6'h26, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0,  5'd12, 32'hFF00_0FF0);
        alu_op("nor",      6'h27, 32'hF0F0_0000, 32'h0F00_000F, 5'd0,  5'd13, 32'h000F_FFF0);
        alu_op("srl",      6'h02, 32'd0,         32'h8000_0000, 5'd31, 5'd14, 32'd1);

        // back-to-back: SLL accepted, OR accepted while in WB
        drive(6'h00, 32'd0, 32'd999, 5'd4, 5'd20);
        tick();
        chk("b2b_ready_wb", {31'b0, in_ready}, 32'd1);
        chk("b2b_sll_en",   {31'b0, wb_en},    32'd1);
        chk("b2b_sll_data", wb_data,           32'd15984);
        drive(6'h25, 32'd55, 32'd72, 5'd0, 5'd21);
        tick();
        in_valid = 1'b0;
        chk("b2b_or_en",   {31'b0, wb_en},   32'd1);
        chk("b2b_or_addr", {27'b0, wb_addr}, 32'd21);
        chk("b2b_or_data", wb_data,          32'd127);
        tick();
        chk("b2b_en_off",  {31'b0, wb_en},   32'd0);

        // rd == 0 suppresses the write
        drive(6'h20, 32'd1, 32'd2, 5'd0, 5'd0);
        tick();
        in_valid = 1'b0;
        chk("rd0_en",      {31'b0, wb_en},   32'd0);
        chk("rd0_illegal", {31'b0, illegal}, 32'd0);
        tick();

        // unsupported funct
        drive(6'h3F, 32'd1, 32'd2, 5'd0, 5'd4);
        tick();
        in_valid = 1'b0;
        chk("ill_pulse", {31'b0, illegal}, 32'd1);
        chk("ill_en",    {31'b0, wb_en},   32'd0);
        tick();
        chk("ill_once",  {31'b0, illegal}, 32'd0);
        chk("ill_ready", {31'b0, in_ready}, 32'd1);

`ifdef EXEC_WB_MUL_EN
        mul_op("mul",      32'd55,        32'd72,       5'd11, 32'd3960);
        mul_op("mul_wrap", 32'hFFFF_FFFF, 32'd3,        5'd15, 32'hFFFF_FFFD);
        mul_op("mul_big",  32'h0001_0001, 32'h0001_0001, 5'd16, 32'h0002_0001);

        // reset in the middle of a multiply
        drive(6'h18, 32'd55, 32'd72, 5'd0, 5'd11);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("rmul_busy_pre", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmul_busy",    {31'b0, busy},    32'd0);
        chk("rmul_wb_en",   {31'b0, wb_en},   32'd0);
        chk("rmul_wb_addr", {27'b0, wb_addr}, 32'd0);
        chk("rmul_wb_data", wb_data,          32'd0);
        chk("rmul_illegal", {31'b0, illegal}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("rmul_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wb_en !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("rmul_no_wb", seen, 0);
`else
        // without the multiplier, MULT is an illegal funct
        drive(6'h18, 32'd55, 32'd72, 5'd0, 5'd11);
        tick();
        in_valid = 1'b0;
        chk("mult_ill",   {31'b0, illegal},  32'd1);
        chk("mult_en",    {31'b0, wb_en},    32'd0);
        chk("mult_busy",  {31'b0, busy},     32'd0);
        chk("mult_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("mult_ill_once", {31'b0, illegal}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wb_en !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("mult_no_wb", seen, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
